// File: rtl/audio_pkg.sv
// Shared audio-path types and constants used by the playback and output stages.
package audio_pkg;

    localparam int AUDIO_FRAC_BITS = 10;
    localparam int AUDIO_OUT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef logic signed [AUDIO_OUT_WIDTH-1:0] sample_t;

endpackage

// File: rtl/fx_saturate.sv
// Signed fixed point to signed integer: arithmetic shift then clamp to OUT_WIDTH.
module fx_saturate #(
    parameter int IN_WIDTH  = 32,
    parameter int FRAC_BITS = 10,
    parameter int OUT_WIDTH = 16
) (
    input  logic signed [IN_WIDTH-1:0]  din,
    output logic signed [OUT_WIDTH-1:0] dout
);

    logic signed [IN_WIDTH-1:0]    shifted;
    logic [IN_WIDTH-OUT_WIDTH:0]   hi;

    always_comb begin
        shifted = din >>> FRAC_BITS;
        hi      = shifted[IN_WIDTH-1:OUT_WIDTH-1];
        // In range only when every bit above the output MSB matches the sign
        if (&hi || ~|hi) begin
            dout = shifted[OUT_WIDTH-1:0];
        end else if (hi[IN_WIDTH-OUT_WIDTH]) begin
            dout = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
            dout = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/pipeline.sv
// Generic delay line: DEPTH register stages with synchronous clear.
module pipeline #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/psola_playback.sv
// Drains the PSOLA output window one word per sample tick, saturates to PCM,
// and zeroes each drained location for the next accumulate pass.
module psola_playback
    import audio_pkg::*;
#(
    parameter int WINDOW_SIZE = 2048,
    parameter int DATA_WIDTH  = 32,
    parameter int FRAC_BITS   = AUDIO_FRAC_BITS,
    parameter int OUT_WIDTH   = AUDIO_OUT_WIDTH,
    parameter int RD_LATENCY  = 2
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           psola_done,
    input  logic [11:0]                    window_len,
    input  logic                           sample_tick,
    output logic [$clog2(WINDOW_SIZE):0]   rd_addr,
    input  logic [DATA_WIDTH-1:0]          rd_data,
    output logic [$clog2(WINDOW_SIZE):0]   clr_addr,
    output logic                           clr_we,
    output logic signed [OUT_WIDTH-1:0]    sample_out,
    output logic                           sample_valid,
    output logic                           busy,
    output logic                           play_done,
    output logic                           overrun
);

    localparam int AW = $clog2(WINDOW_SIZE) + 1;

    function automatic logic [AW-1:0] clamp_len(input logic [11:0] l);
        if (int'(l) > WINDOW_SIZE) begin
            return AW'(WINDOW_SIZE);
        end
        return AW'(l);
    endfunction

    state_t                 state_q, state_d;
    logic [AW-1:0]          k_q, k_d;
    logic [AW-1:0]          len_q, len_d;
    logic                   pend_valid_q, pend_valid_d;
    logic [11:0]            pend_len_q, pend_len_d;
    logic [AW-1:0]          rd_addr_q, rd_addr_d;
    logic [AW-1:0]          clr_addr_q, clr_addr_d;
    logic                   clr_we_q, clr_we_d;
    logic signed [OUT_WIDTH-1:0] sample_out_q, sample_out_d;
    logic                   sample_valid_q, sample_valid_d;
    logic                   busy_q, busy_d;
    logic                   play_done_q, play_done_d;
    logic                   overrun_q, overrun_d;

    logic                   fetch;
    logic [AW:0]            pipe_out;
    logic                   ret_valid;
    logic [AW-1:0]          ret_addr;
    logic signed [OUT_WIDTH-1:0] sat_out;

    // Fetch strobe and address ride alongside the BRAM read latency
    pipeline #(
        .WIDTH (AW + 1),
        .DEPTH (RD_LATENCY)
    ) u_pipe (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .din    ({fetch, k_q}),
        .dout   (pipe_out)
    );

    assign ret_valid = pipe_out[AW];
    assign ret_addr  = pipe_out[AW-1:0];

    fx_saturate #(
        .IN_WIDTH  (DATA_WIDTH),
        .FRAC_BITS (FRAC_BITS),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_sat (
        .din  (rd_data),
        .dout (sat_out)
    );

    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        len_d          = len_q;
        pend_valid_d   = pend_valid_q;
        pend_len_d     = pend_len_q;
        rd_addr_d      = rd_addr_q;
        clr_addr_d     = clr_addr_q;
        clr_we_d       = 1'b0;
        sample_out_d   = sample_out_q;
        sample_valid_d = 1'b0;
        play_done_d    = 1'b0;
        overrun_d      = overrun_q;
        fetch          = 1'b0;

        if (psola_done && state_q != IDLE) begin
            if (pend_valid_q) begin
                overrun_d = 1'b1;
            end
            pend_valid_d = 1'b1;
            pend_len_d   = window_len;
        end

        unique case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    sample_out_d   = '0;
                    sample_valid_d = 1'b1;
                end
                if (psola_done) begin
                    len_d = clamp_len(window_len);
                    k_d   = '0;
                    if (clamp_len(window_len) == '0) begin
                        play_done_d = 1'b1;
                    end else begin
                        state_d = PLAY;
                    end
                end
            end
            PLAY: begin
                if (sample_tick) begin
                    fetch     = 1'b1;
                    rd_addr_d = k_q;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (sample_tick) begin
                    overrun_d = 1'b1;
                end
                if (ret_valid) begin
                    sample_out_d   = sat_out;
                    sample_valid_d = 1'b1;
                    clr_addr_d     = ret_addr;
                    clr_we_d       = 1'b1;
                    k_d            = k_q + 1'b1;
                    if (k_q + 1'b1 == len_q) begin
                        play_done_d = 1'b1;
                        if (pend_valid_d) begin
                            len_d        = clamp_len(pend_len_d);
                            k_d          = '0;
                            pend_valid_d = 1'b0;
                            state_d      = (clamp_len(pend_len_d) == '0) ? IDLE : PLAY;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = PLAY;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q        <= IDLE;
            k_q            <= '0;
            len_q          <= '0;
            pend_valid_q   <= 1'b0;
            pend_len_q     <= '0;
            rd_addr_q      <= '0;
            clr_addr_q     <= '0;
            clr_we_q       <= 1'b0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            play_done_q    <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            len_q          <= len_d;
            pend_valid_q   <= pend_valid_d;
            pend_len_q     <= pend_len_d;
            rd_addr_q      <= rd_addr_d;
            clr_addr_q     <= clr_addr_d;
            clr_we_q       <= clr_we_d;
            sample_out_q   <= sample_out_d;
            sample_valid_q <= sample_valid_d;
            busy_q         <= busy_d;
            play_done_q    <= play_done_d;
            overrun_q      <= overrun_d;
        end
    end

    // Address goes out combinationally so data returns RD_LATENCY after the tick
    assign rd_addr      = rd_addr_d;
    assign clr_addr     = clr_addr_q;
    assign clr_we       = clr_we_q;
    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign busy         = busy_q;
    assign play_done    = play_done_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_psola_playback.sv
// Self-checking bench for psola_playback: BRAM model, scoreboard queue,
// table-driven drain plus hand-written multi-cycle sequences.
module tb_psola_playback;
    import audio_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        psola_done;
    logic [11:0] window_len;
    logic        sample_tick;
    logic [11:0] rd_addr;
    logic [31:0] rd_data;
    logic [11:0] clr_addr;
    logic        clr_we;
    sample_t     sample_out;
    logic        sample_valid;
    logic        busy;
    logic        play_done;
    logic        overrun;

    always #5 clk_in = ~clk_in;

    psola_playback dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .psola_done   (psola_done),
        .window_len   (window_len),
        .sample_tick  (sample_tick),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .clr_addr     (clr_addr),
        .clr_we       (clr_we),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .busy         (busy),
        .play_done    (play_done),
        .overrun      (overrun)
    );

    // BRAM model: two-cycle read, zero write-back, host write port
    logic [31:0] mem [4096] = '{default: 32'h0};
    logic [31:0] d1, d2;
    logic        hw_en;
    logic [11:0] hw_addr;
    logic [31:0] hw_data;

    always @(posedge clk_in) begin
        d1 <= mem[rd_addr];
        d2 <= d1;
        if (clr_we) mem[clr_addr] <= 32'h0;
        if (hw_en) mem[hw_addr] <= hw_data;
    end
    assign rd_data = d2;

    typedef struct {
        logic [15:0] out;
        logic        we;
        logic [11:0] addr;
    } exp_t;

    typedef struct {
        logic [31:0] word;
        logic [15:0] out;
    } vec_t;

    exp_t q[$];
    vec_t vt[9];
    int tests = 0;
    int fails = 0;
    int sv_cnt = 0;
    int pd_cnt = 0;
    int we_cnt = 0;
    int stray_we = 0;
    int base_sv, base_pd, base_we, nz;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic memw(input logic [11:0] a, input logic [31:0] d);
        hw_en = 1'b1;
        hw_addr = a;
        hw_data = d;
        cyc(1);
        hw_en = 1'b0;
    endtask

    task automatic push(input logic [15:0] o, input logic we, input logic [11:0] a);
        exp_t e;
        e.out = o;
        e.we = we;
        e.addr = a;
        q.push_back(e);
    endtask

    task automatic pulse_done(input logic [11:0] l);
        psola_done = 1'b1;
        window_len = l;
        cyc(1);
        psola_done = 1'b0;
        cyc(1);
    endtask

    // One tick, then checks sample_valid appears exactly lat cycles later
    task automatic tick(input int lat);
        sample_tick = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            cyc(1);
            if (i == 1) sample_tick = 1'b0;
            if (lat > 1 && i == lat - 1) chk("lat_early", 64'(sample_valid), 64'd0);
            if (lat > 0 && i == lat) chk("lat", 64'(sample_valid), 64'd1);
        end
    endtask

    initial begin
        rst_in = 1'b1;
        psola_done = 1'b0;
        window_len = '0;
        sample_tick = 1'b0;
        hw_en = 1'b0;
        hw_addr = '0;
        hw_data = '0;

        fork
            forever begin
                @(negedge clk_in);
                if (play_done) pd_cnt++;
                if (clr_we) we_cnt++;
                if (sample_valid) begin
                    sv_cnt++;
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_sample: got %0h expected none at %0t",
                                 sample_out, $time);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("sample_out", 64'($unsigned(sample_out)), 64'(e.out));
                        chk("clr_we", 64'(clr_we), 64'(e.we));
                        if (e.we) chk("clr_addr", 64'(clr_addr), 64'(e.addr));
                    end
                end else if (clr_we) begin
                    stray_we++;
                end
            end
        join_none

        vt[0] = '{32'h0000_0400, 16'h0001};
        vt[1] = '{32'h0000_0800, 16'h0002};
        vt[2] = '{32'hFFFF_FC00, 16'hFFFF};
        vt[3] = '{32'h0000_0000, 16'h0000};
        vt[4] = '{32'h7FFF_FFFF, 16'h7FFF};
        vt[5] = '{32'h8000_0000, 16'h8000};
        vt[6] = '{32'h01FF_FC00, 16'h7FFF};
        vt[7] = '{32'hFE00_0000, 16'h8000};
        vt[8] = '{32'h0200_0000, 16'h7FFF};

        cyc(3);
        rst_in = 1'b0;
        cyc(1);
        chk("rst_sample_out", 64'($unsigned(sample_out)), 64'd0);
        chk("rst_sample_valid", 64'(sample_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_play_done", 64'(play_done), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_clr_we", 64'(clr_we), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);

        // Table-driven drain: basic values plus saturation boundaries
        for (int i = 0; i < 9; i++) memw(12'(i), vt[i].word);
        base_pd = pd_cnt;
        pulse_done(12'd9);
        chk("drain_busy_hi", 64'(busy), 64'd1);
        for (int i = 0; i < 9; i++) begin
            push(vt[i].out, 1'b1, 12'(i));
            tick(3);
        end
        chk("drain_play_done", 64'(pd_cnt - base_pd), 64'd1);
        chk("drain_busy_lo", 64'(busy), 64'd0);
        nz = 0;
        for (int i = 0; i < 9; i++) if (mem[i] != 32'h0) nz++;
        chk("drain_cleared", 64'(nz), 64'd0);

        // Zero-length window
        base_pd = pd_cnt;
        psola_done = 1'b1;
        window_len = 12'd0;
        cyc(1);
        psola_done = 1'b0;
        chk("len0_play_done", 64'(play_done), 64'd1);
        chk("len0_busy", 64'(busy), 64'd0);
        cyc(1);
        chk("len0_play_done_pulse", 64'(play_done), 64'd0);

        // Idle ticks
        base_sv = sv_cnt;
        base_we = we_cnt;
        for (int i = 0; i < 3; i++) begin
            push(16'h0, 1'b0, 12'h0);
            tick(1);
        end
        chk("idle_sv", 64'(sv_cnt - base_sv), 64'd3);
        chk("idle_we", 64'(we_cnt - base_we), 64'd0);
        chk("idle_overrun", 64'(overrun), 64'd0);

        // Back-to-back windows
        base_pd = pd_cnt;
        base_sv = sv_cnt;
        memw(12'd0, 32'h0000_1400);
        memw(12'd1, 32'h0000_1800);
        memw(12'd2, 32'h0000_1C00);
        pulse_done(12'd3);
        push(16'd5, 1'b1, 12'd0);
        tick(3);
        pulse_done(12'd2);
        push(16'd6, 1'b1, 12'd1);
        tick(3);
        memw(12'd0, 32'h0000_2400);
        memw(12'd1, 32'h0000_2800);
        push(16'd7, 1'b1, 12'd2);
        tick(3);
        chk("b2b_busy", 64'(busy), 64'd1);
        push(16'd9, 1'b1, 12'd0);
        tick(3);
        push(16'd10, 1'b1, 12'd1);
        tick(3);
        chk("b2b_sv", 64'(sv_cnt - base_sv), 64'd5);
        chk("b2b_play_done", 64'(pd_cnt - base_pd), 64'd2);
        chk("b2b_busy_lo", 64'(busy), 64'd0);

        // psola_done on the cycle of the last sample_valid
        base_pd = pd_cnt;
        memw(12'd0, 32'h0000_0C00);
        pulse_done(12'd1);
        push(16'd3, 1'b1, 12'd0);
        sample_tick = 1'b1;
        cyc(1);
        sample_tick = 1'b0;
        cyc(2);
        chk("last_sv", 64'(sample_valid), 64'd1);
        psola_done = 1'b1;
        window_len = 12'd1;
        cyc(1);
        psola_done = 1'b0;
        chk("last_restart_busy", 64'(busy), 64'd1);
        memw(12'd0, 32'h0000_1400);
        cyc(5);
        push(16'd5, 1'b1, 12'd0);
        tick(3);
        chk("last_play_done", 64'(pd_cnt - base_pd), 64'd2);
        chk("last_overrun", 64'(overrun), 64'd0);

        // Tick overrun
        base_sv = sv_cnt;
        memw(12'd0, 32'h0000_1000);
        pulse_done(12'd1);
        push(16'd4, 1'b1, 12'd0);
        sample_tick = 1'b1;
        cyc(2);
        sample_tick = 1'b0;
        cyc(8);
        chk("ovr_flag", 64'(overrun), 64'd1);
        chk("ovr_sv", 64'(sv_cnt - base_sv), 64'd1);

        // Reset mid-drain
        for (int i = 0; i < 8; i++) memw(12'(i), 32'h400 * (i + 1));
        pulse_done(12'd8);
        base_we = we_cnt;
        base_sv = sv_cnt;
        sample_tick = 1'b1;
        cyc(1);
        sample_tick = 1'b0;
        rst_in = 1'b1;
        cyc(1);
        rst_in = 1'b0;
        chk("mrst_sample_out", 64'($unsigned(sample_out)), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_overrun", 64'(overrun), 64'd0);
        chk("mrst_rd_addr", 64'(rd_addr), 64'd0);
        chk("mrst_clr_we", 64'(clr_we), 64'd0);
        cyc(8);
        chk("mrst_no_we", 64'(we_cnt - base_we), 64'd0);
        chk("mrst_no_sv", 64'(sv_cnt - base_sv), 64'd0);
        push(16'h0, 1'b0, 12'h0);
        tick(1);
        chk("mrst_mem_kept", 64'(mem[0]), 64'h400);

        cyc(4);
        chk("queue_empty", 64'(q.size()), 64'd0);
        chk("stray_clr_we", 64'(stray_we), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
